// File: rtl/ecc_scalar_mult_ctrl_if.sv
// Request/response bus between the scalar-multiplication sequencer and the shared
// point-arithmetic unit. The master modport is the sequencer; the slave is the point unit.
interface ecc_scalar_mult_ctrl_if #(
  parameter int MAX_BITS = 256
) ();
  logic                op_req;
  logic                op_sel;
  logic [MAX_BITS-1:0] op_ax;
  logic [MAX_BITS-1:0] op_ay;
  logic [MAX_BITS-1:0] op_bx;
  logic [MAX_BITS-1:0] op_by;
  logic                op_done;
  logic [MAX_BITS-1:0] op_rx;
  logic [MAX_BITS-1:0] op_ry;
  logic                op_rinf;

  modport master (
    output op_req,
    output op_sel,
    output op_ax,
    output op_ay,
    output op_bx,
    output op_by,
    input  op_done,
    input  op_rx,
    input  op_ry,
    input  op_rinf
  );

  modport slave (
    input  op_req,
    input  op_sel,
    input  op_ax,
    input  op_ay,
    input  op_bx,
    input  op_by,
    output op_done,
    output op_rx,
    output op_ry,
    output op_rinf
  );
endinterface

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for k*P over a shared point-arithmetic unit.
// Optional per-op watchdog is built only when ECC_CTRL_TIMEOUT_EN is defined.
module ecc_scalar_mult_ctrl #(
  parameter int MAX_BITS       = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic [MAX_BITS-1:0]    i_k,
  input  logic [MAX_BITS-1:0]    i_px,
  input  logic [MAX_BITS-1:0]    i_py,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [MAX_BITS-1:0]    o_rx,
  output logic [MAX_BITS-1:0]    o_ry,
  output logic                   o_rinf,
  output logic                   o_err,
  ecc_scalar_mult_ctrl_if.master op
);

  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  if ((TIMEOUT_CYCLES < 1) || (MAX_BITS < 32)) begin : g_cfg_check
    $error("ecc_scalar_mult_ctrl: TIMEOUT_CYCLES must be >= 1 and MAX_BITS >= 32");
  end

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DBL,
    DBL_W,
    ADD,
    ADD_W,
    DONE
  } state_t;

  // Index of the most significant scalar bit for the requested operand width.
  function automatic logic [IDX_W-1:0] top_index(input logic [1:0] mode);
    int w;
    w = 32 << mode;
    if (w > MAX_BITS) w = MAX_BITS;
    return IDX_W'(w - 1);
  endfunction

  state_t              state;
  state_t              state_nx;
  logic [IDX_W-1:0]    idx;
  logic [MAX_BITS-1:0] k_q;
  logic [MAX_BITS-1:0] px_q;
  logic [MAX_BITS-1:0] py_q;
  logic [MAX_BITS-1:0] r_x;
  logic [MAX_BITS-1:0] r_y;
  logic                r_inf;
  logic                req_q;
  logic                sel_q;

  logic cur_bit;
  logic last_bit;
  logic load;
  logic r_load_p;
  logic r_load_op;
  logic step;
  logic issue_dbl;
  logic issue_add;
  logic finish;
  logic abort;
  logic timeout;

  assign cur_bit  = k_q[idx];
  assign last_bit = (idx == '0);

  assign op.op_req = req_q;
  assign op.op_sel = sel_q;
  assign op.op_ax  = r_x;
  assign op.op_ay  = r_y;
  assign op.op_bx  = px_q;
  assign op.op_by  = py_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    r_load_p  = 1'b0;
    r_load_op = 1'b0;
    step      = 1'b0;
    issue_dbl = 1'b0;
    issue_add = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load     = 1'b1;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        // Until the first set bit the accumulator is infinity, so no doubling is needed.
        if (!r_inf) begin
          state_nx = DBL;
        end else begin
          r_load_p = cur_bit;
          step     = 1'b1;
        end
      end
      DBL: begin
        issue_dbl = 1'b1;
        state_nx  = DBL_W;
      end
      DBL_W: begin
        if (op.op_done) begin
          // Adding P to infinity is just P, so skip the point unit in that case.
          if (cur_bit && op.op_rinf) begin
            r_load_p = 1'b1;
            step     = 1'b1;
          end else begin
            r_load_op = 1'b1;
            if (cur_bit) state_nx = ADD;
            else         step     = 1'b1;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      ADD: begin
        issue_add = 1'b1;
        state_nx  = ADD_W;
      end
      ADD_W: begin
        if (op.op_done) begin
          r_load_op = 1'b1;
          step      = 1'b1;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      DONE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (step)  state_nx = last_bit ? DONE : SCAN;
    if (abort) state_nx = IDLE;
  end

  // The scalar is only read while a run is active, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) k_q <= i_k;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      px_q   <= '0;
      py_q   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_inf  <= 1'b1;
      req_q  <= 1'b0;
      sel_q  <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_rx   <= '0;
      o_ry   <= '0;
      o_rinf <= 1'b0;
    end else begin
      req_q  <= issue_dbl | issue_add;
      o_done <= finish | abort;
      if (load) begin
        idx    <= top_index(i_mode);
        px_q   <= i_px;
        py_q   <= i_py;
        r_inf  <= 1'b1;
        o_busy <= 1'b1;
      end
      if (step && !last_bit) idx <= idx - 1'b1;
      if (r_load_p) begin
        r_x   <= px_q;
        r_y   <= py_q;
        r_inf <= 1'b0;
      end else if (r_load_op) begin
        r_x   <= op.op_rx;
        r_y   <= op.op_ry;
        r_inf <= op.op_rinf;
      end
      if (issue_dbl) sel_q <= 1'b0;
      if (issue_add) sel_q <= 1'b1;
      if (finish) begin
        o_rx   <= r_x;
        o_ry   <= r_y;
        o_rinf <= r_inf;
      end
      if (abort) o_rinf <= 1'b1;
      if (finish || abort) o_busy <= 1'b0;
    end
  end

`ifdef ECC_CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              waiting;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  assign waiting = (state == DBL_W) || (state == ADD_W);

  // Counter is zero in the cycle op_req is high, so expiry lands TIMEOUT_CYCLES after the request.
  always_ff @(posedge clk) begin
    if (rst)                         wait_cnt <= '0;
    else if (issue_dbl || issue_add) wait_cnt <= '0;
    else if (waiting)                wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  assign timeout = waiting && !op.op_done && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (load)  err_q <= 1'b0;
    else if (abort) err_q <= 1'b1;
  end

  assign o_err = err_q;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl: a toy point unit (coordinate-wise integer group mod 2^256)
// answers requests, and expected results, op sequences and latencies are queued per run.
module tb_ecc_scalar_mult_ctrl;
  localparam int MB = 256;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [1:0]    i_mode;
  logic [MB-1:0] i_k, i_px, i_py;
  logic          o_busy, o_done, o_rinf, o_err;
  logic [MB-1:0] o_rx, o_ry;

  ecc_scalar_mult_ctrl_if #(.MAX_BITS(MB)) op_if ();

  ecc_scalar_mult_ctrl #(.MAX_BITS(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_k(i_k),
    .i_px(i_px), .i_py(i_py), .o_busy(o_busy), .o_done(o_done), .o_rx(o_rx),
    .o_ry(o_ry), .o_rinf(o_rinf), .o_err(o_err), .op(op_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [MB-1:0] rx;
    logic [MB-1:0] ry;
    logic          rinf;
    string         ops;
    int            cycles;
  } exp_t;
  exp_t sb[$];

  // Point-unit model: double = 2A, add = A+B, infinity = (0,0); op_done comes lat cycles after op_req.
  int            lat     = 3;
  bit            respond = 1'b1;
  int            pending = 0;
  string         op_log  = "";
  logic [MB-1:0] res_x, res_y;

  initial begin
    op_if.op_done = 1'b0;
    op_if.op_rx   = '0;
    op_if.op_ry   = '0;
    op_if.op_rinf = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      op_if.op_done = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          op_if.op_rx   = res_x;
          op_if.op_ry   = res_y;
          op_if.op_rinf = (res_x == '0) && (res_y == '0);
          op_if.op_done = 1'b1;
        end
      end
      if (op_if.op_req === 1'b1) begin
        if (op_if.op_sel === 1'b1) begin
          res_x  = op_if.op_ax + op_if.op_bx;
          res_y  = op_if.op_ay + op_if.op_by;
          op_log = {op_log, "A"};
        end else begin
          res_x  = op_if.op_ax << 1;
          res_y  = op_if.op_ay << 1;
          op_log = {op_log, "D"};
        end
        if (respond) pending = lat;
      end
    end
  end

  function automatic string exp_ops(input logic [MB-1:0] k, input int w);
    string s;
    bit    seen;
    s    = "";
    seen = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (seen) begin
        s = {s, "D"};
        if (k[i]) s = {s, "A"};
      end else if (k[i]) begin
        seen = 1'b1;
      end
    end
    return s;
  endfunction

  // o_done is seen one cycle after the width + 2*ops + sum(latency) + 1 cycles of sequencing.
  task automatic push_exp(input logic [1:0] mode, input logic [MB-1:0] k, input logic [MB-1:0] px,
                          input logic [MB-1:0] py);
    exp_t          e;
    int            w;
    logic [MB-1:0] km, one;
    w   = 32 << mode;
    one = 1;
    km  = (w >= MB) ? k : (k & ((one << w) - one));
    e.rx     = km * px;
    e.ry     = km * py;
    e.rinf   = (km == '0);
    e.ops    = exp_ops(km, w);
    e.cycles = w + (2 + lat) * e.ops.len() + 2;
    sb.push_back(e);
  endtask

  logic [MB-1:0] cap_rx, cap_ry;
  logic          cap_rinf, cap_err, cap_busy_at_done, cap_done_after;

  task automatic run_op(input logic [1:0] mode, input logic [MB-1:0] k, input logic [MB-1:0] px,
                        input logic [MB-1:0] py, input int extra_at, output int cyc,
                        output bit busy_ok, output bit done_seen);
    op_log = "";
    @(negedge clk);
    i_mode  = mode;
    i_k     = k;
    i_px    = px;
    i_py    = py;
    i_start = 1'b1;
    @(negedge clk);
    i_start   = 1'b0;
    cyc       = 1;
    busy_ok   = 1'b1;
    done_seen = 1'b1;
    while (o_done !== 1'b1) begin
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == extra_at) begin
        i_start = 1'b1;
        i_k     = '0;
      end else begin
        i_start = 1'b0;
      end
      if (cyc >= 20000) begin
        done_seen = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    i_start          = 1'b0;
    cap_rx           = o_rx;
    cap_ry           = o_ry;
    cap_rinf         = o_rinf;
    cap_err          = o_err;
    cap_busy_at_done = o_busy;
    @(negedge clk);
    cap_done_after = o_done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_rinf, o_err, op_if.op_req, op_if.op_sel} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {o_busy, o_done, o_rinf, o_err, op_if.op_req, op_if.op_sel});
    end
    checks++;
    if ((o_rx | o_ry | op_if.op_ax | op_if.op_ay | op_if.op_bx | op_if.op_by) !== '0) begin
      errors++;
      $display("FAIL reset_data got rx=%0h ax=%0h bx=%0h want 0", o_rx, op_if.op_ax, op_if.op_bx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_k1();
    exp_t e;
    int   cyc;
    bit   bok, dseen;
    lat = 3;
    push_exp(2'b00, 1, 5, 7);
    run_op(2'b00, 1, 5, 7, -1, cyc, bok, dseen);
    e = sb.pop_front();
    checks++;
    if (!dseen) begin errors++; $display("FAIL k1_done got none want pulse"); end
    checks++;
    if (cyc !== 34) begin errors++; $display("FAIL k1_latency got %0d want 34", cyc); end
    checks++;
    if (op_log != e.ops) begin errors++; $display("FAIL k1_ops got '%s' want '%s'", op_log, e.ops); end
    checks++;
    if ({cap_rx, cap_ry, cap_rinf} !== {e.rx, e.ry, e.rinf}) begin
      errors++;
      $display("FAIL k1_result got (%0h,%0h,%b) want (%0h,%0h,%b)", cap_rx, cap_ry, cap_rinf, e.rx, e.ry, e.rinf);
    end
    checks++;
    if ({cap_busy_at_done, cap_done_after, cap_err} !== 3'b000) begin
      errors++;
      $display("FAIL k1_done_shape got %b want 000", {cap_busy_at_done, cap_done_after, cap_err});
    end
  endtask

  task automatic test_zero();
    exp_t e;
    int   cyc;
    bit   bok, dseen;
    push_exp(2'b00, 0, 9, 11);
    run_op(2'b00, 0, 9, 11, -1, cyc, bok, dseen);
    e = sb.pop_front();
    checks++;
    if (cyc !== e.cycles || !dseen) begin errors++; $display("FAIL zero_latency got %0d want %0d", cyc, e.cycles); end
    checks++;
    if (op_log != "") begin errors++; $display("FAIL zero_ops got '%s' want ''", op_log); end
    checks++;
    if (cap_rinf !== 1'b1) begin errors++; $display("FAIL zero_rinf got %b want 1", cap_rinf); end
  endtask

  task automatic test_k5();
    exp_t          e;
    int            cyc;
    bit            bok, dseen;
    logic [MB-1:0] px, py;
    px  = 256'h1234_5678_9abc_def1_0fed_cba9_8765_4321;
    py  = 256'h0bad_cafe_0000_0003;
    lat = 3;
    push_exp(2'b00, 5, px, py);
    run_op(2'b00, 5, px, py, -1, cyc, bok, dseen);
    e = sb.pop_front();
    checks++;
    if (op_log != "DDA") begin errors++; $display("FAIL k5_ops got '%s' want 'DDA'", op_log); end
    checks++;
    if ({cap_rx, cap_ry, cap_rinf} !== {e.rx, e.ry, e.rinf}) begin
      errors++;
      $display("FAIL k5_result got (%0h,%0h,%b) want (%0h,%0h,%b)", cap_rx, cap_ry, cap_rinf, e.rx, e.ry, e.rinf);
    end
    checks++;
    if (cyc !== e.cycles) begin errors++; $display("FAIL k5_latency got %0d want %0d", cyc, e.cycles); end
  endtask

  task automatic test_all_ones();
    exp_t          e;
    int            cyc;
    bit            bok, dseen;
    string         want;
    logic [MB-1:0] px, py;
    px   = 256'h3;
    py   = 256'h7_0000_0001;
    lat  = 1;
    want = "";
    for (int i = 0; i < 31; i++) want = {want, "DA"};
    push_exp(2'b00, 32'hFFFF_FFFF, px, py);
    run_op(2'b00, 32'hFFFF_FFFF, px, py, 10, cyc, bok, dseen);
    e = sb.pop_front();
    checks++;
    if (op_log != want) begin errors++; $display("FAIL ones_ops got '%s' want '%s'", op_log, want); end
    checks++;
    if (!bok || !dseen) begin errors++; $display("FAIL ones_busy got busy_ok=%b done=%b want 1 1", bok, dseen); end
    checks++;
    if ({cap_rx, cap_ry, cap_rinf} !== {e.rx, e.ry, e.rinf}) begin
      errors++;
      $display("FAIL ones_result got (%0h,%0h,%b) want (%0h,%0h,%b)", cap_rx, cap_ry, cap_rinf, e.rx, e.ry, e.rinf);
    end
    checks++;
    if (cyc !== e.cycles) begin errors++; $display("FAIL ones_latency got %0d want %0d", cyc, e.cycles); end
  endtask

  task automatic test_mode_mask();
    exp_t          e;
    int            cyc;
    bit            bok, dseen;
    logic [MB-1:0] k;
    k      = '0;
    k[100] = 1'b1;
    k[1:0] = 2'b11;
    lat    = 2;
    push_exp(2'b01, k, 256'h11, 256'h23);
    run_op(2'b01, k, 256'h11, 256'h23, -1, cyc, bok, dseen);
    e = sb.pop_front();
    checks++;
    if (op_log != "DA") begin errors++; $display("FAIL mask_ops got '%s' want 'DA'", op_log); end
    checks++;
    if ({cap_rx, cap_ry, cap_rinf} !== {256'h33, 256'h69, 1'b0}) begin
      errors++;
      $display("FAIL mask_result got (%0h,%0h,%b) want (33,69,0)", cap_rx, cap_ry, cap_rinf);
    end
    checks++;
    if (cyc !== e.cycles) begin errors++; $display("FAIL mask_latency got %0d want %0d", cyc, e.cycles); end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int   cyc, n;
    bit   bok, dseen, quiet;
    lat = 6;
    @(negedge clk);
    i_mode  = 2'b00;
    i_k     = 32'hC000_0000;
    i_px    = 256'h5;
    i_py    = 256'h7;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (op_if.op_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL midrst_req got none want op_req"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_busy !== 1'b0 || op_if.op_req !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL midrst_quiet got activity want none"); end
    checks++;
    if ({o_rinf, o_err, op_if.op_sel} !== 3'b000 ||
        (o_rx | o_ry | op_if.op_ax | op_if.op_ay | op_if.op_bx | op_if.op_by) !== '0) begin
      errors++;
      $display("FAIL midrst_state got ax=%0h ay=%0h bx=%0h rinf=%b want 0", op_if.op_ax, op_if.op_ay, op_if.op_bx, o_rinf);
    end
    lat = 2;
    push_exp(2'b00, 2, 256'h5, 256'h7);
    run_op(2'b00, 2, 256'h5, 256'h7, -1, cyc, bok, dseen);
    e = sb.pop_front();
    checks++;
    if (op_log != "D") begin errors++; $display("FAIL midrst_k2_ops got '%s' want 'D'", op_log); end
    checks++;
    if ({cap_rx, cap_ry, cap_rinf} !== {256'hA, 256'hE, 1'b0} || cyc !== e.cycles) begin
      errors++;
      $display("FAIL midrst_k2_result got (%0h,%0h,%b) cyc %0d want (a,e,0) cyc %0d", cap_rx, cap_ry, cap_rinf, cyc, e.cycles);
    end
  endtask

  task automatic test_top_bit();
    exp_t          e;
    int            cyc;
    bit            bok, dseen;
    logic [MB-1:0] k;
    k      = '0;
    k[255] = 1'b1;
    k[0]   = 1'b1;
    lat    = 1;
    push_exp(2'b11, k, 256'h9, 256'h15);
    run_op(2'b11, k, 256'h9, 256'h15, -1, cyc, bok, dseen);
    e = sb.pop_front();
    checks++;
    if ({cap_rx, cap_ry, cap_rinf} !== {e.rx, e.ry, e.rinf} || op_log.len() != 256) begin
      errors++;
      $display("FAIL top_result got (%0h,%b) ops %0d want (%0h,%b) ops 256", cap_rx, cap_rinf, op_log.len(), e.rx, e.rinf);
    end
    checks++;
    if (cyc !== e.cycles) begin errors++; $display("FAIL top_latency got %0d want %0d", cyc, e.cycles); end
  endtask

`ifdef ECC_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n, cyc;
    bit bok, dseen;
    respond = 1'b0;
    @(negedge clk);
    i_mode  = 2'b00;
    i_k     = 3;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (op_if.op_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (o_done !== 1'b1 && n < 4 * TO) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== TO) begin errors++; $display("FAIL timeout_latency got %0d want %0d", n, TO); end
    checks++;
    if ({o_err, o_rinf, o_busy} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_flags got %b want 110", {o_err, o_rinf, o_busy});
    end
    respond = 1'b1;
    repeat (3) @(negedge clk);
    run_op(2'b00, 1, 5, 7, -1, cyc, bok, dseen);
    checks++;
    if (cap_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear got %b want 0", cap_err); end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    i_mode  = 2'b00;
    i_k     = '0;
    i_px    = '0;
    i_py    = '0;
    test_reset();
    test_k1();
    test_zero();
    test_k5();
    test_all_ones();
    test_mode_mask();
    test_reset_mid_op();
    test_top_bit();
`ifdef ECC_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/ecc_scalar_mult_ctrl.md
Name: ecc_scalar_mult_ctrl

Overview:
- Sequencer for the ECC scalar-multiplication datapath. Runs left-to-right double-and-add over a latched scalar (k·P).
- Issues one point-double or point-add request at a time to a shared point-arithmetic unit and tracks the accumulator point, including the point at infinity.
- Sits between the serial I/O wrapper and the point-arithmetic unit; invoked once for aP and once for abP.

Parameters:
- MAX_BITS, 256, width of the scalar and of each coordinate.
- TIMEOUT_CYCLES, 4096, watchdog limit per op (used only with ECC_CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_mode  in  2  operand width: 00=32, 01=64, 10=128, 11=256 bits
- i_k  in  MAX_BITS  scalar; bits at or above the mode width are ignored
- i_px, i_py  in  MAX_BITS  base point P (finite by contract)
- o_busy  out  1  high from the cycle after start is accepted until DONE exits
- o_done  out  1  one-cycle pulse when the result is valid
- o_rx, o_ry  out  MAX_BITS  result coordinates; held until the next accepted start
- o_rinf  out  1  result is the point at infinity
- o_err  out  1  watchdog abort flag (tied 0 without ECC_CTRL_TIMEOUT_EN)
- op_req  out  1  one-cycle request pulse to the point unit
- op_sel  out  1  0=double(A), 1=add(A,B)
- op_ax, op_ay  out  MAX_BITS  operand A = accumulator R, held stable while waiting
- op_bx, op_by  out  MAX_BITS  operand B = latched P
- op_done  in  1  result valid pulse from the point unit
- op_rx, op_ry  in  MAX_BITS  op result
- op_rinf  in  1  op result is infinity

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; o_busy, o_done, o_rinf, o_err, op_req, op_sel = 0; o_rx, o_ry, op_ax, op_ay, op_bx, op_by = 0. A reset mid-operation abandons the run; any op_done arriving afterwards is ignored.
- IDLE: on i_start, latch k, P and mode; set idx = width-1; set R=∞ (R_inf=1); go to SCAN. i_start in any other state is ignored.
- SCAN (examines bit k[idx]):
  - R_inf=1, bit=0: no op; step.
  - R_inf=1, bit=1: R←P, R_inf←0 in one cycle, no op; step.
  - R_inf=0: go to DBL.
- DBL: pulse op_req with op_sel=0; go to DBL_W.
- DBL_W: wait for op_done. Then R←(op_rx, op_ry), R_inf←op_rinf. If bit=1 and op_rinf=0, go to ADD; if bit=1 and op_rinf=1, set R←P, R_inf←0 (no op) and step; otherwise step.
- ADD: pulse op_req with op_sel=1; go to ADD_W.
- ADD_W: wait for op_done, then latch R and R_inf from the result; step.
- step: if idx==0 go to DONE, else idx←idx-1 and go to SCAN.
- DONE: o_rx, o_ry ← R; o_rinf ← R_inf; pulse o_done for 1 cycle; return to IDLE; o_busy falls in the same cycle.
- op_done outside DBL_W/ADD_W is ignored. op_done arriving in the same cycle as op_req is not legal (the unit's minimum latency is 1).
- Op counts:
  - Leading zeros cost 1 cycle each.
  - After the first set bit, each remaining bit costs 1 double, plus 1 add if the bit is set.
  - SCAN adds 1 cycle per bit. Total cycles = width + 2·(ops) + Σ(op latencies) + 1.
- Scalar equal to 0 within the width: o_rinf=1, zero requests issued.

Optional Feature:
- Macro: ECC_CTRL_TIMEOUT_EN.
- When defined: a wait counter runs in DBL_W/ADD_W. If it reaches TIMEOUT_CYCLES without op_done, the controller sets o_err=1, sets o_rinf=1, pulses o_done and returns to IDLE. o_err clears on the next accepted start.
- When not defined: no counter is built, o_err is tied 0, and the controller waits on op_done indefinitely.

Test Plan:
- mode=00, k=1, P=(5,7) -> zero op_req pulses; o_done once with o_rx=5, o_ry=7, o_rinf=0; o_done exactly 34 cycles after the start-sample edge.
- mode=00, k=0 -> zero ops; o_rinf=1; o_done after 34 cycles.
- mode=00, k=5, point-unit model with 3-cycle latency -> op_sel sequence 0,0,1; accumulator passes 2P, 4P, 5P; result equals the model's 5P.
- mode=00, k=0xFFFFFFFF -> 31 doubles and 31 adds, alternating D,A; o_busy stays high throughout; a second i_start pulse mid-run is ignored.
- mode=01, k has bit 100 set plus k[63:0]=3 -> bit 100 is ignored; ops D,A; result 3P.
- rst asserted in DBL_W, then op_done arrives -> no state change, all outputs at reset values; next start with k=2 gives ops D only and result 2P. With ECC_CTRL_TIMEOUT_EN and a model that never sends op_done -> o_err=1 and o_done exactly TIMEOUT_CYCLES after op_req.
